// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller.
//   state_e       : controller FSM states (ST_STEP only exists when PIPE_STEP_EN is defined)
//   FWD_*         : operand forwarding select codes driven on fwd_a / fwd_b
//   PC_*          : next-PC source codes driven on pc_src
//   STG_*         : bit positions of each pipeline stage in stage_en / stage_rst
//   fwd_select()  : forwarding priority decode for one source operand
package pipe_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_RUN     = 3'd1,
    ST_MEMWAIT = 3'd2,
    ST_HALT    = 3'd3
`ifdef PIPE_STEP_EN
    ,
    ST_STEP    = 3'd4
`endif
  } state_e;

  localparam logic [1:0] FWD_RF       = 2'd0;
  localparam logic [1:0] FWD_EXE_ALU  = 2'd1;
  localparam logic [1:0] FWD_MEM_ALU  = 2'd2;
  localparam logic [1:0] FWD_MEM_LOAD = 2'd3;

  localparam logic [1:0] PC_NEXT   = 2'd0;
  localparam logic [1:0] PC_JUMP   = 2'd1;
  localparam logic [1:0] PC_BRANCH = 2'd2;

  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EXE = 2;

  localparam logic [4:0] STAGES_ALL  = 5'b11111;
  localparam logic [4:0] STAGES_NONE = 5'b00000;

  // The youngest producer wins. A load still in EXE has no data yet, so it
  // is never a forwarding source; that case is the load-use stall instead.
  function automatic logic [1:0] fwd_select(
    input logic [4:0] src,
    input logic [4:0] exe_dst,
    input logic       exe_wen,
    input logic       exe_load,
    input logic [4:0] mem_dst,
    input logic       mem_wen,
    input logic       mem_load
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (exe_wen && !exe_load && (exe_dst != 5'd0) && (exe_dst == src)) begin
      sel = FWD_EXE_ALU;
    end else if (mem_wen && (mem_dst != 5'd0) && (mem_dst == src)) begin
      sel = mem_load ? FWD_MEM_LOAD : FWD_MEM_ALU;
    end
    return sel;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Control bundle between the five-stage datapath and pipeline_ctrl.
//   ID-stage decode : addr_rs, addr_rt, rs_used, rt_used, is_jump, is_beq, is_bne, rs_rt_equal
//   EXE/MEM info    : regw_addr_exe, regw_addr_mem, wb_wen_exe, wb_wen_mem, is_load_exe, is_load_mem
//   memory          : mem_req, mem_ack
//   debug           : run, step
//   controls out    : stage_en, stage_rst, fwd_a, fwd_b, pc_src
//   status out      : halted, mem_err, stall_cycles (CNT_W bits)
// master = datapath side, slave = controller side.
interface pipeline_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       addr_rs;
  logic [4:0]       addr_rt;
  logic             rs_used;
  logic             rt_used;
  logic             is_jump;
  logic             is_beq;
  logic             is_bne;
  logic             rs_rt_equal;
  logic [4:0]       regw_addr_exe;
  logic [4:0]       regw_addr_mem;
  logic             wb_wen_exe;
  logic             wb_wen_mem;
  logic             is_load_exe;
  logic             is_load_mem;
  logic             mem_req;
  logic             mem_ack;
  logic             run;
  logic             step;
  logic [4:0]       stage_en;
  logic [4:0]       stage_rst;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [1:0]       pc_src;
  logic             halted;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output addr_rs, addr_rt, rs_used, rt_used, is_jump, is_beq, is_bne, rs_rt_equal,
           regw_addr_exe, regw_addr_mem, wb_wen_exe, wb_wen_mem, is_load_exe, is_load_mem,
           mem_req, mem_ack, run, step,
    input  stage_en, stage_rst, fwd_a, fwd_b, pc_src, halted, mem_err, stall_cycles
  );

  modport slave (
    input  addr_rs, addr_rt, rs_used, rt_used, is_jump, is_beq, is_bne, rs_rt_equal,
           regw_addr_exe, regw_addr_mem, wb_wen_exe, wb_wen_mem, is_load_exe, is_load_mem,
           mem_req, mem_ack, run, step,
    output stage_en, stage_rst, fwd_a, fwd_b, pc_src, halted, mem_err, stall_cycles
  );
endinterface

// File: rtl/hazard_fwd_unit.sv
// Combinational load-use hazard detection and operand forwarding decode.
//   inputs  : ID source addresses/usage, EXE and MEM destination, write-enable and load flags
//   outputs : hazard_o (load in EXE feeds an operand read in ID), fwd_a_o / fwd_b_o selects
module hazard_fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] addr_rs_i,
  input  logic [4:0] addr_rt_i,
  input  logic       rs_used_i,
  input  logic       rt_used_i,
  input  logic [4:0] regw_addr_exe_i,
  input  logic [4:0] regw_addr_mem_i,
  input  logic       wb_wen_exe_i,
  input  logic       wb_wen_mem_i,
  input  logic       is_load_exe_i,
  input  logic       is_load_mem_i,
  output logic       hazard_o,
  output logic [1:0] fwd_a_o,
  output logic [1:0] fwd_b_o
);

  logic rs_hit;
  logic rt_hit;

  // Writes to $0 are discarded by the register file, so they never create a dependency.
  assign rs_hit = rs_used_i && (addr_rs_i == regw_addr_exe_i);
  assign rt_hit = rt_used_i && (addr_rt_i == regw_addr_exe_i);

  assign hazard_o = is_load_exe_i && wb_wen_exe_i && (regw_addr_exe_i != 5'd0) &&
                    (rs_hit || rt_hit);

  assign fwd_a_o = fwd_select(addr_rs_i, regw_addr_exe_i, wb_wen_exe_i, is_load_exe_i,
                              regw_addr_mem_i, wb_wen_mem_i, is_load_mem_i);
  assign fwd_b_o = fwd_select(addr_rt_i, regw_addr_exe_i, wb_wen_exe_i, is_load_exe_i,
                              regw_addr_mem_i, wb_wen_mem_i, is_load_mem_i);

endmodule

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline controller: stage enables/resets, forwarding selects,
// next-PC source, memory-wait timeout and stall performance counter.
//   clk, rst : single clock, asynchronous active-high reset
//   bus      : pipeline_ctrl_if.slave (decode/hazard inputs in, controls and status out)
// Parameters : MEM_TIMEOUT (frozen MEM cycles before error), CNT_W (stall counter width)
// Build option: define PIPE_STEP_EN to add the single-step debug state; the
//   controller then leaves reset into HALT instead of RUN.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input logic            clk,
  input logic            rst,
  pipeline_ctrl_if.slave bus
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  // The cycle that stalled in RUN is the first frozen cycle, so MEMWAIT gives
  // up once the count of earlier frozen cycles reaches MEM_TIMEOUT-1.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       hazard;
  logic [1:0] fwd_a_raw;
  logic [1:0] fwd_b_raw;
  logic       taken;
  logic       mem_stall;

  logic [4:0] en;
  logic [4:0] srst;
  logic [1:0] pc_sel;
  logic       fwd_on;
  logic       halted_w;

  hazard_fwd_unit u_hazard_fwd (
    .addr_rs_i       (bus.addr_rs),
    .addr_rt_i       (bus.addr_rt),
    .rs_used_i       (bus.rs_used),
    .rt_used_i       (bus.rt_used),
    .regw_addr_exe_i (bus.regw_addr_exe),
    .regw_addr_mem_i (bus.regw_addr_mem),
    .wb_wen_exe_i    (bus.wb_wen_exe),
    .wb_wen_mem_i    (bus.wb_wen_mem),
    .is_load_exe_i   (bus.is_load_exe),
    .is_load_mem_i   (bus.is_load_mem),
    .hazard_o        (hazard),
    .fwd_a_o         (fwd_a_raw),
    .fwd_b_o         (fwd_b_raw)
  );

  assign taken = bus.is_jump ||
                 (bus.is_beq && bus.rs_rt_equal) ||
                 (bus.is_bne && !bus.rs_rt_equal);

  assign mem_stall = bus.mem_req && !bus.mem_ack;

`ifndef PIPE_STEP_EN
  logic unused_step;
  assign unused_step = bus.step;
`endif

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    err_d    = err_q;
    en       = STAGES_ALL;
    srst     = STAGES_NONE;
    pc_sel   = PC_NEXT;
    fwd_on   = 1'b1;
    halted_w = 1'b0;

    case (state_q)
      ST_INIT: begin
        en     = STAGES_NONE;
        srst   = STAGES_ALL;
        fwd_on = 1'b0;
`ifdef PIPE_STEP_EN
        state_d = ST_HALT;
`else
        state_d = ST_RUN;
`endif
      end

      ST_RUN: begin
        // A pending memory access freezes everything, so it outranks the
        // load-use stall, which in turn outranks a redirect.
        if (mem_stall) begin
          en = STAGES_NONE;
          if (MEM_TIMEOUT <= 1) begin
            err_d   = 1'b1;
            wait_d  = '0;
            state_d = ST_HALT;
          end else begin
            wait_d  = WAIT_W'(1);
            state_d = ST_MEMWAIT;
          end
        end else if (hazard) begin
          en[STG_IF]    = 1'b0;
          en[STG_ID]    = 1'b0;
          srst[STG_EXE] = 1'b1;
        end else if (taken) begin
          pc_sel       = bus.is_jump ? PC_JUMP : PC_BRANCH;
          srst[STG_ID] = 1'b1;
        end
      end

      ST_MEMWAIT: begin
        if (bus.mem_ack) begin
          wait_d  = '0;
          state_d = ST_RUN;
        end else begin
          en = STAGES_NONE;
          if (wait_q >= WAIT_LAST) begin
            err_d   = 1'b1;
            wait_d  = '0;
            state_d = ST_HALT;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end
      end

      ST_HALT: begin
        en       = STAGES_NONE;
        halted_w = 1'b1;
        if (bus.run) begin
          state_d = ST_RUN;
`ifdef PIPE_STEP_EN
        end else if (bus.step) begin
          state_d = ST_STEP;
`endif
        end
      end

`ifdef PIPE_STEP_EN
      ST_STEP: begin
        state_d = ST_HALT;
      end
`endif

      default: begin
        en      = STAGES_NONE;
        srst    = STAGES_ALL;
        fwd_on  = 1'b0;
        state_d = ST_INIT;
      end
    endcase
  end

  // INIT and HALT are not stalls of a running program, so they are not counted.
  always_comb begin
    cnt_d = cnt_q;
    if ((state_q != ST_INIT) && (state_q != ST_HALT) && (en != STAGES_ALL) &&
        (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_INIT;
      wait_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.stage_en     = en;
  assign bus.stage_rst    = srst;
  assign bus.fwd_a        = fwd_on ? fwd_a_raw : FWD_RF;
  assign bus.fwd_b        = fwd_on ? fwd_b_raw : FWD_RF;
  assign bus.pc_src       = pc_sel;
  assign bus.halted       = halted_w;
  assign bus.mem_err      = err_q;
  assign bus.stall_cycles = cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios followed by random
// stimulus, all outputs compared every cycle against a behavioural model.
module tb_pipeline_ctrl;

  localparam int TIMEOUT = 16;
  localparam int CW      = 8;
  localparam int CNT_MAX = (1 << CW) - 1;
`ifdef PIPE_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  localparam int M_INIT = 0;
  localparam int M_RUN  = 1;
  localparam int M_WAIT = 2;
  localparam int M_HALT = 3;
  localparam int M_STEP = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipeline_ctrl_if #(.CNT_W(CW)) bus ();

  pipeline_ctrl #(.MEM_TIMEOUT(TIMEOUT), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  int m_mode;
  int m_wait;
  int m_stall;
  int m_err;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode  = M_INIT;
    m_wait  = 0;
    m_stall = 0;
    m_err   = 0;
  endtask

  function automatic int ref_fwd(input logic [4:0] src);
    if (bus.wb_wen_exe && !bus.is_load_exe && bus.regw_addr_exe != 0 && bus.regw_addr_exe == src)
      return 1;
    if (bus.wb_wen_mem && !bus.is_load_mem && bus.regw_addr_mem != 0 && bus.regw_addr_mem == src)
      return 2;
    if (bus.wb_wen_mem && bus.is_load_mem && bus.regw_addr_mem != 0 && bus.regw_addr_mem == src)
      return 3;
    return 0;
  endfunction

  function automatic bit ref_hazard();
    return bus.is_load_exe && bus.wb_wen_exe && bus.regw_addr_exe != 0 &&
           ((bus.rs_used && bus.addr_rs == bus.regw_addr_exe) ||
            (bus.rt_used && bus.addr_rt == bus.regw_addr_exe));
  endfunction

  function automatic bit ref_taken();
    return bus.is_jump || (bus.is_beq && bus.rs_rt_equal) || (bus.is_bne && !bus.rs_rt_equal);
  endfunction

  // One clock: expected outputs at the falling edge, model advance at the rising edge.
  task automatic run_cycle();
    int e_en, e_rst, e_fa, e_fb, e_pc, e_halt, nxt, nwait, set_err;
    @(negedge clk);
    e_en = 31; e_rst = 0; e_pc = 0; e_halt = 0; set_err = 0;
    e_fa = ref_fwd(bus.addr_rs);
    e_fb = ref_fwd(bus.addr_rt);
    nxt = m_mode; nwait = m_wait;
    case (m_mode)
      M_INIT: begin
        e_en = 0; e_rst = 31; e_fa = 0; e_fb = 0;
        nxt = STEP_EN ? M_HALT : M_RUN;
      end
      M_RUN: begin
        if (bus.mem_req && !bus.mem_ack) begin
          e_en = 0; nwait = 1; nxt = M_WAIT;
        end else if (ref_hazard()) begin
          e_en = 5'b11100; e_rst = 5'b00100;
        end else if (ref_taken()) begin
          e_pc = bus.is_jump ? 1 : 2; e_rst = 5'b00010;
        end
      end
      M_WAIT: begin
        if (bus.mem_ack) begin
          nxt = M_RUN; nwait = 0;
        end else begin
          e_en = 0; nwait = m_wait + 1;
          if (nwait >= TIMEOUT) begin set_err = 1; nxt = M_HALT; nwait = 0; end
        end
      end
      M_HALT: begin
        e_en = 0; e_halt = 1;
        if (bus.run) nxt = M_RUN;
        else if (STEP_EN && bus.step) nxt = M_STEP;
      end
      default: nxt = M_HALT;
    endcase
    check_val("stage_en", 32'(bus.stage_en), 32'(e_en));
    check_val("stage_rst", 32'(bus.stage_rst), 32'(e_rst));
    check_val("fwd_a", 32'(bus.fwd_a), 32'(e_fa));
    check_val("fwd_b", 32'(bus.fwd_b), 32'(e_fb));
    check_val("pc_src", 32'(bus.pc_src), 32'(e_pc));
    check_val("halted", 32'(bus.halted), 32'(e_halt));
    check_val("mem_err", 32'(bus.mem_err), 32'(m_err));
    check_val("stall_cycles", 32'(bus.stall_cycles), 32'(m_stall));
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (e_en != 31 && m_mode != M_INIT && m_mode != M_HALT && m_stall < CNT_MAX)
        m_stall++;
      if (set_err != 0) m_err = 1;
      m_mode = nxt;
      m_wait = nwait;
    end
    #1;
  endtask

  task automatic clear_inputs();
    bus.addr_rs = '0; bus.addr_rt = '0; bus.rs_used = 1'b0; bus.rt_used = 1'b0;
    bus.is_jump = 1'b0; bus.is_beq = 1'b0; bus.is_bne = 1'b0; bus.rs_rt_equal = 1'b0;
    bus.regw_addr_exe = '0; bus.regw_addr_mem = '0;
    bus.wb_wen_exe = 1'b0; bus.wb_wen_mem = 1'b0;
    bus.is_load_exe = 1'b0; bus.is_load_mem = 1'b0;
    bus.mem_req = 1'b0; bus.mem_ack = 1'b0;
    bus.run = 1'b1; bus.step = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    rst = 1'b1;
    clear_inputs();
    model_reset();
    repeat (2) run_cycle();
    rst = 1'b0;
    run_cycle();

`ifdef PIPE_STEP_EN
    // Leaves reset halted; a step pulse gives exactly one enabled cycle.
    bus.run = 1'b0;
    check_val("step_reset_halted", 32'(bus.halted), 32'd1);
    bus.step = 1'b1;
    run_cycle();
    bus.step = 1'b0;
    #1 check_val("step_one_cycle_en", 32'(bus.stage_en), 32'h1F);
    run_cycle();
    #1 check_val("step_back_halted", 32'(bus.halted), 32'd1);
    run_cycle();
    bus.run = 1'b1;
    run_cycle();
`endif
    repeat (2) run_cycle();

    // lw $1 in EXE while ID reads $1, then the load moves to MEM.
    bus.is_load_exe = 1'b1; bus.wb_wen_exe = 1'b1; bus.regw_addr_exe = 5'd1;
    bus.rs_used = 1'b1; bus.addr_rs = 5'd1;
    #1 check_val("loaduse_en", 32'(bus.stage_en), 32'h1C);
    check_val("loaduse_rst", 32'(bus.stage_rst), 32'h04);
    run_cycle();
    bus.is_load_exe = 1'b0; bus.wb_wen_exe = 1'b0; bus.regw_addr_exe = 5'd0;
    bus.is_load_mem = 1'b1; bus.wb_wen_mem = 1'b1; bus.regw_addr_mem = 5'd1;
    #1 check_val("loaduse_fwd_a", 32'(bus.fwd_a), 32'd3);
    run_cycle();

    // $2 written in both EXE and MEM: EXE wins; destination $0 never forwards.
    clear_inputs();
    bus.wb_wen_exe = 1'b1; bus.regw_addr_exe = 5'd2;
    bus.wb_wen_mem = 1'b1; bus.regw_addr_mem = 5'd2;
    bus.rs_used = 1'b1; bus.addr_rs = 5'd2;
    #1 check_val("fwd_exe_prio", 32'(bus.fwd_a), 32'd1);
    run_cycle();
    bus.regw_addr_exe = 5'd0; bus.regw_addr_mem = 5'd0; bus.addr_rs = 5'd0;
    #1 check_val("fwd_dest_zero", 32'(bus.fwd_a), 32'd0);
    run_cycle();

    // Taken beq, then the same beq together with a load-use hazard.
    clear_inputs();
    bus.is_beq = 1'b1; bus.rs_rt_equal = 1'b1;
    #1 check_val("beq_pc_src", 32'(bus.pc_src), 32'd2);
    check_val("beq_flush", 32'(bus.stage_rst), 32'h02);
    run_cycle();
    bus.is_load_exe = 1'b1; bus.wb_wen_exe = 1'b1; bus.regw_addr_exe = 5'd3;
    bus.rt_used = 1'b1; bus.addr_rt = 5'd3;
    #1 check_val("beq_vs_hazard_pc", 32'(bus.pc_src), 32'd0);
    run_cycle();

    // Memory acknowledged after three frozen cycles.
    clear_inputs();
    base = m_stall;
    bus.mem_req = 1'b1;
    repeat (3) run_cycle();
    bus.mem_ack = 1'b1;
    #1 check_val("memack_all_en", 32'(bus.stage_en), 32'h1F);
    run_cycle();
    clear_inputs();
    #1 check_val("memwait_stall_count", 32'(bus.stall_cycles), 32'(base + 3));
    run_cycle();

    // No acknowledge: error and halt after TIMEOUT frozen cycles, then resume.
    bus.run = 1'b0;
    bus.mem_req = 1'b1;
    repeat (TIMEOUT) run_cycle();
    #1 check_val("timeout_halted", 32'(bus.halted), 32'd1);
    check_val("timeout_mem_err", 32'(bus.mem_err), 32'd1);
    bus.mem_req = 1'b0;
    run_cycle();
    bus.run = 1'b1;
    run_cycle();
    run_cycle();

    // Asynchronous reset while waiting on memory.
    bus.mem_req = 1'b1;
    repeat (2) run_cycle();
    #2 rst = 1'b1;
    model_reset();
    #1 check_val("async_rst_en", 32'(bus.stage_en), 32'd0);
    check_val("async_rst_stage_rst", 32'(bus.stage_rst), 32'h1F);
    check_val("async_rst_mem_err", 32'(bus.mem_err), 32'd0);
    check_val("async_rst_stall", 32'(bus.stall_cycles), 32'd0);
    run_cycle();
    rst = 1'b0;
    clear_inputs();
    repeat (3) run_cycle();

    // Random traffic; periodic windows without acknowledge provoke timeouts.
    for (int i = 0; i < 3000; i++) begin
      bus.addr_rs       = 5'($urandom_range(0, 3));
      bus.addr_rt       = 5'($urandom_range(0, 3));
      bus.rs_used       = 1'($urandom_range(0, 1));
      bus.rt_used       = 1'($urandom_range(0, 1));
      bus.is_jump       = ($urandom_range(0, 7) == 0);
      bus.is_beq        = ($urandom_range(0, 3) == 0);
      bus.is_bne        = ($urandom_range(0, 3) == 0);
      bus.rs_rt_equal   = 1'($urandom_range(0, 1));
      bus.regw_addr_exe = 5'($urandom_range(0, 3));
      bus.regw_addr_mem = 5'($urandom_range(0, 3));
      bus.wb_wen_exe    = 1'($urandom_range(0, 1));
      bus.wb_wen_mem    = 1'($urandom_range(0, 1));
      bus.is_load_exe   = 1'($urandom_range(0, 1));
      bus.is_load_mem   = 1'($urandom_range(0, 1));
      bus.mem_req       = ($urandom_range(0, 7) == 0);
      bus.mem_ack       = ((i % 600) < 80) ? 1'b0 : ($urandom_range(0, 3) == 0);
      bus.run           = ($urandom_range(0, 5) == 0);
      bus.step          = ($urandom_range(0, 3) == 0);
      run_cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
